uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

Serial receive front end of the program-load path: samples the asynchronous UART line with 16x oversampling and deframes 8N1 characters. It presents each received byte on `data_out` together with a one-cycle `rx_done` strobe. The byte-to-instruction assembler connects directly to these outputs, using `rx_done` as its write enable and `data_out` as its byte input.

## Interface
- `BAUD_DIV`, 27: system clocks per oversample tick (50 MHz / (115200 × 16) ≈ 27); legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; 1 start bit, no parity, 1 stop bit.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: asynchronous serial line; idles high.
- `data_out` out `DATA_BITS`: last correctly framed byte, LSB received first.
- `rx_done` out 1: one-cycle pulse; `data_out` is valid in the same cycle.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer, producing `rx_sync`. A third flop, `rx_prev`, holds the previous `rx_sync`. All three reset to 1.
- **Tick generator.** Free-running counter 0..`BAUD_DIV`-1. `tick` is high for one clock when the count equals `BAUD_DIV`-1, then the counter wraps to 0. The counter is cleared only by reset.
- **Counters.** 4-bit sample counter `s`. Bit counter `n` of width $clog2(`DATA_BITS`). Shift register `sh`.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE**
  - A falling edge (`rx_prev`=1 and `rx_sync`=0) sets `s`=0 and moves to START.
  - A line held low does not start a frame.
- **START** (action on `tick` only)
  - If `s`==7 and `rx_sync`==0: go to DATA with `s`=0, `n`=0.
  - If `s`==7 and `rx_sync`==1: glitch; return to IDLE with no outputs asserted.
  - Otherwise: `s`++.
- **DATA** (action on `tick` only)
  - If `s`==15: set `s`=0 and `sh` = {`rx_sync`, `sh[DATA_BITS-1:1]`}. If `n`==`DATA_BITS`-1, go to STOP; otherwise `n`++.
  - Otherwise: `s`++.
- **STOP** (action on `tick` only)
  - If `s`==15 and `rx_sync`==1: load `data_out`←`sh`, pulse `rx_done`, go to IDLE.
  - If `s`==15 and `rx_sync`==0: pulse `frame_err`, leave `data_out` unchanged, go to IDLE.
  - Otherwise: `s`++.
- **Output registers.** `rx_done` and `frame_err` are registered and are never high together. `data_out` holds its value until the next good frame.
- **`busy`.** Combinational decode: `busy` = (state != IDLE).

## Timing
- **Reset values:** `data_out`=0, `rx_done`=0, `frame_err`=0, `busy`=0, state=IDLE, all counters 0, `sh`=0.
- **Reset mid-frame:** the frame is abandoned immediately. Nothing is emitted for the partial frame.
- **Input latency:** 2 clocks from `rx` to `rx_sync`. Start detection occurs 1 clock after `rx_sync` falls.
- **Sample points:**
  - Start bit is confirmed at 8 ticks.
  - Each data bit is sampled 16 ticks after the previous sample, i.e. at bit centres.
  - Tick phase jitter is ≤1 tick, i.e. ≤1/16 bit.
- **Bit period:** Tb = 16 × `BAUD_DIV` clocks.
- **Strobe timing:** `rx_done` or `frame_err` rises on the clock edge following the stop-bit sampling tick. This is about 9.5 Tb + 3 clocks (±1 tick) after the start-bit falling edge of `rx`. The strobe is high for exactly one clock.
- **Back-to-back frames:** the FSM is in IDLE by mid-stop-bit. A following start edge, even with zero idle time, is therefore detected.
- **Break condition:** after `frame_err` with the line still low, the block stays in IDLE until `rx` returns high and then falls again.
- **Downstream handshake:** none. Consumers must accept a byte on every `rx_done`; there is no backpressure.

## Test plan
All scenarios use `BAUD_DIV`=4, so Tb = 64 clocks.
- **Reset:** `arst_n`=0 with `rx`=1, then release → `data_out`=0x00, `rx_done`=0, `frame_err`=0, `busy`=0, and all stay so while `rx` idles high for 20 Tb.
- **Single byte:** send 0xA5 (8N1, LSB first) → exactly one `rx_done` pulse of 1 clock, `data_out`=0xA5 in that cycle, `busy` back to 0 before the stop bit ends.
- **Back-to-back with zero idle:** send 0x01, 0x13, 0x05, 0x00, 0x00 → five `rx_done` pulses, with `data_out` = 0x01, 0x13, 0x05, 0x00, 0x00 in order, no `frame_err`.
- **Start glitch:** drive `rx` low for 12 clocks (3 ticks), then high → no `rx_done`, no `frame_err`, `busy` returns to 0 within 8 ticks. A following 0x3C frame is received correctly.
- **Framing error and break:**
  - Send 0x3C with stop bit 0, then hold `rx` low for 5 Tb → one `frame_err` pulse, no `rx_done`, `data_out` keeps its prior value, `busy` stays 0 during the break.
  - Release the line high for 1 Tb, then send 0x7E → `rx_done` with `data_out`=0x7E.
- **Reset mid-frame:** assert `arst_n` low during data bit 4 of 0xFF, release, idle 2 Tb, then send 0x5A → no strobe from the aborted frame, one `rx_done` with `data_out`=0x5A.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling. Each good byte appears on data_out
// together with a one-cycle rx_done strobe, and a bad stop bit gives a frame_err strobe.
module uart_rx_byte #(
    parameter int BAUD_DIV  = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int DIV_W = $clog2(BAUD_DIV);
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0]     div_q;
    logic                 tick;
    logic [3:0]           s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    assign tick = (div_q == DIV_LAST);

    // The sync flops reset high so that releasing reset on an idle line is not taken as a start edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            div_q     <= tick ? '0 : div_q + 1'b1;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_sync_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d  = '0;
                        sh_d = {rx_sync_q, sh_q[DATA_BITS-1:1]};
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d     = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        state_d = IDLE;
                        if (rx_sync_q) begin
                            data_d = sh_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at BAUD_DIV=4: table vectors, hand-written
// corner sequences and random frames checked against a frame-level model.
module tb_uart_rx_byte;
    localparam int TBIT   = 64;
    localparam int LAT_LO = 9 * TBIT + TBIT / 2 + 3 - 4;
    localparam int LAT_HI = 9 * TBIT + TBIT / 2 + 3 + 4;

    logic       clk;
    logic       arst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    ev_t  evq[$];
    ev_t  expq[$];
    vec_t tbl[8];
    logic done_prev = 1'b0;
    logic ferr_prev = 1'b0;

    uart_rx_byte #(.BAUD_DIV(4), .DATA_BITS(8)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx        (rx),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every strobe and checks its per-pulse properties.
    always @(negedge clk) begin
        if (arst_n && (rx_done || frame_err)) begin
            checks++;
            if (rx_done && frame_err) begin
                failures++;
                $display("FAIL both_strobes rx_done=%b frame_err=%b required not both", rx_done, frame_err);
            end
            checks++;
            if ((rx_done && done_prev) || (frame_err && ferr_prev)) begin
                failures++;
                $display("FAIL strobe_width got a second high cycle at cyc=%0d required one cycle", cyc);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_at_strobe got=%b want=0", busy);
            end
            evq.push_back('{err: frame_err, data: data_out, cyc: cyc});
        end
        done_prev = rx_done;
        ferr_prev = frame_err;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop, output int start_cyc);
        rx = 1'b0;
        start_cyc = cyc;
        hold(TBIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(TBIT);
        end
        rx = stop;
        hold(TBIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap,
                              input logic exp_err, input logic [7:0] exp_data);
        int sc;
        send_bits(b, stop, sc);
        expq.push_back('{err: exp_err, data: exp_data, cyc: sc});
        if (gap > 0) begin
            rx = 1'b1;
            hold(gap);
        end
    endtask

    task automatic check_batch(input string tag);
        int lat;
        rx = 1'b1;
        hold(2 * TBIT);
        checks++;
        if (evq.size() != expq.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d strobes want=%0d", tag, evq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            checks++;
            if (evq[i].err !== expq[i].err) begin
                failures++;
                $display("FAIL %s_kind[%0d] got frame_err=%b want=%b", tag, i, evq[i].err, expq[i].err);
            end
            checks++;
            if (evq[i].data !== expq[i].data) begin
                failures++;
                $display("FAIL %s_data[%0d] got=0x%02h want=0x%02h", tag, i, evq[i].data, expq[i].data);
            end
            lat = evq[i].cyc - expq[i].cyc;
            checks++;
            if (lat < LAT_LO || lat > LAT_HI) begin
                failures++;
                $display("FAIL %s_latency[%0d] got=%0d want=%0d..%0d", tag, i, lat, LAT_LO, LAT_HI);
            end
        end
        evq.delete();
        expq.delete();
    endtask

    initial begin
        logic [7:0] last_good;
        logic [7:0] b;
        logic       stop;
        int         gap;
        int         viol;
        int         sc;

        tbl[0] = '{data: 8'hA5, stop: 1'b1, gap: 64, exp_err: 1'b0, exp_data: 8'hA5};
        tbl[1] = '{data: 8'h01, stop: 1'b1, gap: 0,  exp_err: 1'b0, exp_data: 8'h01};
        tbl[2] = '{data: 8'h13, stop: 1'b1, gap: 0,  exp_err: 1'b0, exp_data: 8'h13};
        tbl[3] = '{data: 8'h05, stop: 1'b1, gap: 0,  exp_err: 1'b0, exp_data: 8'h05};
        tbl[4] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_err: 1'b0, exp_data: 8'h00};
        tbl[5] = '{data: 8'h00, stop: 1'b1, gap: 64, exp_err: 1'b0, exp_data: 8'h00};
        tbl[6] = '{data: 8'hC3, stop: 1'b0, gap: 64, exp_err: 1'b1, exp_data: 8'h00};
        tbl[7] = '{data: 8'h5F, stop: 1'b1, gap: 37, exp_err: 1'b0, exp_data: 8'h5F};

        // Reset and quiet idle line.
        arst_n = 1'b0;
        rx     = 1'b1;
        hold(5);
        arst_n = 1'b1;
        hold(1);
        check("reset_data_out", data_out, 8'h00);
        check("reset_rx_done", rx_done, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        viol = 0;
        for (int i = 0; i < 20 * TBIT; i++) begin
            @(negedge clk);
            if (rx_done || frame_err || busy || data_out != 8'h00) viol++;
        end
        hold(1);
        check("idle_quiet_cycles", viol, 0);

        // Table vectors: single byte, zero-idle back-to-back, framing error.
        for (int i = 0; i < 8; i++)
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, tbl[i].exp_err, tbl[i].exp_data);
        check_batch("table");

        // Start glitch of 3 ticks.
        rx = 1'b0;
        hold(8);
        check("glitch_busy_seen", busy, 1'b1);
        hold(4);
        rx = 1'b1;
        hold(36);
        check("glitch_busy_cleared", busy, 1'b0);
        check("glitch_no_strobe", evq.size(), 0);
        send_frame(8'h3C, 1'b1, 64, 1'b0, 8'h3C);
        check_batch("glitch");

        // Framing error followed by a 5-bit break, then recovery.
        send_frame(8'h99, 1'b1, 40, 1'b0, 8'h99);
        send_bits(8'h3C, 1'b0, sc);
        expq.push_back('{err: 1'b1, data: 8'h99, cyc: sc});
        viol = 0;
        for (int i = 0; i < 5 * TBIT; i++) begin
            @(negedge clk);
            if (busy || rx_done || frame_err) viol++;
        end
        hold(1);
        check("break_quiet_cycles", viol, 0);
        check("break_data_out", data_out, 8'h99);
        rx = 1'b1;
        hold(TBIT);
        send_frame(8'h7E, 1'b1, 20, 1'b0, 8'h7E);
        check_batch("break");
        last_good = 8'h7E;

        // Random frames against a frame-level model.
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? int'($urandom_range(0, 70)) : int'($urandom_range(8, 70));
            if (stop) last_good = b;
            send_frame(b, stop, gap, !stop, last_good);
        end
        check_batch("random");

        // Reset during data bit 4 of 0xFF.
        rx = 1'b0;
        hold(TBIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            hold(TBIT);
        end
        hold(TBIT / 2);
        check("midframe_busy_before_reset", busy, 1'b1);
        arst_n = 1'b0;
        hold(4);
        check("midframe_reset_busy", busy, 1'b0);
        check("midframe_reset_data_out", data_out, 8'h00);
        arst_n = 1'b1;
        hold(2 * TBIT);
        check("midframe_no_strobe", evq.size(), 0);
        check("midframe_idle_busy", busy, 1'b0);
        send_frame(8'h5A, 1'b1, 10, 1'b0, 8'h5A);
        check_batch("midframe");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
